// File: rtl/dpram_sweep.sv
// Single-clock true dual-port RAM with a clear engine. Read latency is 1 cycle, or 2 with OUT_REG=1.
// There is no backpressure: while the sweep runs (busy=1), port accesses are dropped and the outputs hold.
module dpram_sweep #(
  parameter int              AW             = 10,
  parameter int              DW             = 7,
  parameter int              READ_MODE      = 0,
  parameter int              OUT_REG        = 0,
  parameter logic [DW-1:0]   FILL           = '0,
  parameter bit              CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  output logic          busy,
  input  logic          cea,
  input  logic          wrea,
  input  logic          ocea,
  input  logic [AW-1:0] ada,
  input  logic [DW-1:0] dina,
  output logic [DW-1:0] douta,
  input  logic          ceb,
  input  logic          wreb,
  input  logic          oceb,
  input  logic [AW-1:0] adb,
  input  logic [DW-1:0] dinb,
  output logic [DW-1:0] doutb
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = '1;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [DW-1:0] r_s1a, r_s1b, r_oa, r_ob;
  logic          w_busy, w_acc, w_fill, w_wea, w_web, w_web_keep;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clear) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_cnt == LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // resetn gates writes so an edge seen while reset is held never touches the array.
  always_comb begin
    w_busy     = (r_state == S_CLEAR);
    w_acc      = (r_state == S_IDLE);
    w_fill     = w_busy & resetn;
    w_wea      = w_acc & resetn & cea & wrea;
    w_web      = w_acc & resetn & ceb & wreb;
    w_web_keep = w_web & ~(w_wea && (ada == adb));
  end

  assign busy = w_busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 r_cnt <= '0;
    else if (r_state == S_CLEAR) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    else if (clear)              r_cnt <= '0;
  end

  // Port A wins a same-address write collision; port B's write is dropped.
  always_ff @(posedge clk) begin
    if (w_fill)     r_mem[r_cnt] <= FILL;
    if (w_wea)      r_mem[ada]   <= dina;
    if (w_web_keep) r_mem[adb]   <= dinb;
  end

  // Stage 1 reads the pre-edge array, so cross-port reads always see the old word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1a <= '0;
      r_s1b <= '0;
    end else begin
      if (w_acc && cea) r_s1a <= (READ_MODE == 1 && wrea) ? dina : r_mem[ada];
      if (w_acc && ceb) r_s1b <= (READ_MODE == 1 && wreb) ? dinb : r_mem[adb];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_oa <= '0;
      r_ob <= '0;
    end else begin
      if (w_acc && ocea) r_oa <= r_s1a;
      if (w_acc && oceb) r_ob <= r_s1b;
    end
  end

  assign douta = (OUT_REG == 1) ? r_oa : r_s1a;
  assign doutb = (OUT_REG == 1) ? r_ob : r_s1b;

endmodule

// File: tb/tb_dpram_sweep.sv
// Directed bench for dpram_sweep: four instances share one stimulus (read-first, write-first,
// output-registered, no clear on reset) and are checked against hand-computed values.
module tb_dpram_sweep;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       clear = 1'b0;
  logic       cea = 1'b0, wrea = 1'b0, ocea = 1'b1;
  logic       ceb = 1'b0, wreb = 1'b0, oceb = 1'b1;
  logic [3:0] ada = '0, adb = '0;
  logic [6:0] dina = '0, dinb = '0;
  logic       busy0, busy1, busy2, busy3;
  logic [6:0] douta0, doutb0, douta1, doutb1, douta2, doutb2, douta3, doutb3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dpram_sweep #(.AW(4), .DW(7), .READ_MODE(0), .OUT_REG(0), .FILL(7'h55), .CLEAR_ON_RESET(1'b1)) u0 (
    .clk(clk), .resetn(resetn), .clear(clear), .busy(busy0),
    .cea(cea), .wrea(wrea), .ocea(ocea), .ada(ada), .dina(dina), .douta(douta0),
    .ceb(ceb), .wreb(wreb), .oceb(oceb), .adb(adb), .dinb(dinb), .doutb(doutb0));
  dpram_sweep #(.AW(4), .DW(7), .READ_MODE(1), .OUT_REG(0), .FILL(7'h55), .CLEAR_ON_RESET(1'b1)) u1 (
    .clk(clk), .resetn(resetn), .clear(clear), .busy(busy1),
    .cea(cea), .wrea(wrea), .ocea(ocea), .ada(ada), .dina(dina), .douta(douta1),
    .ceb(ceb), .wreb(wreb), .oceb(oceb), .adb(adb), .dinb(dinb), .doutb(doutb1));
  dpram_sweep #(.AW(4), .DW(7), .READ_MODE(0), .OUT_REG(1), .FILL(7'h55), .CLEAR_ON_RESET(1'b1)) u2 (
    .clk(clk), .resetn(resetn), .clear(clear), .busy(busy2),
    .cea(cea), .wrea(wrea), .ocea(ocea), .ada(ada), .dina(dina), .douta(douta2),
    .ceb(ceb), .wreb(wreb), .oceb(oceb), .adb(adb), .dinb(dinb), .doutb(doutb2));
  dpram_sweep #(.AW(4), .DW(7), .READ_MODE(0), .OUT_REG(0), .FILL(7'h55), .CLEAR_ON_RESET(1'b0)) u3 (
    .clk(clk), .resetn(resetn), .clear(clear), .busy(busy3),
    .cea(cea), .wrea(wrea), .ocea(ocea), .ada(ada), .dina(dina), .douta(douta3),
    .ceb(ceb), .wreb(wreb), .oceb(oceb), .adb(adb), .dinb(dinb), .doutb(doutb3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    cea = 1'b0; wrea = 1'b0; ceb = 1'b0; wreb = 1'b0; clear = 1'b0;
  endtask

  // Counts cycles with busy0 high, starting from the current cycle.
  task automatic count_busy(output int n);
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    #2 resetn = 1'b0;
    #2;
    checks++; if ({douta0, doutb0, douta1, doutb1, douta2, doutb2} !== 42'd0) begin
      failures++; $display("FAIL reset_douts got=%h exp=0", {douta0, doutb0, douta1, doutb1, douta2, doutb2});
    end
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL reset_busy_cor1 got=%b exp=1", busy0); end
    checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL reset_busy_cor0 got=%b exp=0", busy3); end
    tick();
    resetn = 1'b1;
    count_busy(n);
    checks++; if (n != 16) begin failures++; $display("FAIL reset_sweep_len got=%0d exp=16", n); end
    checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL cor0_idle got=%b exp=0", busy3); end
    for (int i = 0; i < 16; i++) begin
      ceb = 1'b1; adb = 4'(i);
      tick();
      checks++; if (doutb0 !== 7'h55 || doutb1 !== 7'h55) begin
        failures++; $display("FAIL fill_read@%0d got=%h/%h exp=55", i, doutb0, doutb1);
      end
    end
    idle_ports();
    tick();
    checks++; if (doutb2 !== 7'h55) begin failures++; $display("FAIL fill_read_oreg got=%h exp=55", doutb2); end
  endtask

  task automatic test_write_read();
    cea = 1'b1; wrea = 1'b1; ada = 4'd3; dina = 7'h12;
    tick();
    idle_ports();
    ceb = 1'b1; adb = 4'd3;
    tick();
    checks++; if (doutb0 !== 7'h12 || doutb1 !== 7'h12) begin
      failures++; $display("FAIL wr_then_rd got=%h/%h exp=12", doutb0, doutb1);
    end
    idle_ports();
  endtask

  task automatic test_out_reg();
    ceb = 1'b1; adb = 4'd0; oceb = 1'b1;
    tick();
    tick();
    checks++; if (doutb2 !== 7'h55) begin failures++; $display("FAIL oreg_prime got=%h exp=55", doutb2); end
    oceb = 1'b0; adb = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (doutb2 !== 7'h55) begin failures++; $display("FAIL oreg_hold%0d got=%h exp=55", i, doutb2); end
    end
    oceb = 1'b1;
    tick();
    checks++; if (doutb2 !== 7'h12) begin failures++; $display("FAIL oreg_release got=%h exp=12", doutb2); end
    idle_ports();
  endtask

  task automatic test_rdw();
    cea = 1'b1; wrea = 1'b1; ada = 4'd5; dina = 7'h0A;
    tick();
    dina = 7'h33; ceb = 1'b1; adb = 4'd5;
    tick();
    checks++; if (douta0 !== 7'h0A) begin failures++; $display("FAIL rdw_read_first got=%h exp=0a", douta0); end
    checks++; if (douta1 !== 7'h33) begin failures++; $display("FAIL rdw_write_first got=%h exp=33", douta1); end
    checks++; if (doutb0 !== 7'h0A || doutb1 !== 7'h0A) begin
      failures++; $display("FAIL rdw_cross_old got=%h/%h exp=0a", doutb0, doutb1);
    end
    idle_ports();
    ceb = 1'b1; adb = 4'd5;
    tick();
    checks++; if (douta2 !== 7'h0A) begin failures++; $display("FAIL rdw_oreg_a got=%h exp=0a", douta2); end
    checks++; if (doutb0 !== 7'h33) begin failures++; $display("FAIL rdw_stored got=%h exp=33", doutb0); end
    idle_ports();
  endtask

  task automatic test_collision();
    cea = 1'b1; wrea = 1'b1; ada = 4'd7; dina = 7'h11;
    ceb = 1'b1; wreb = 1'b1; adb = 4'd7; dinb = 7'h22;
    tick();
    checks++; if (douta0 !== 7'h55 || doutb0 !== 7'h55) begin
      failures++; $display("FAIL coll_rf got=%h/%h exp=55/55", douta0, doutb0);
    end
    checks++; if (douta1 !== 7'h11 || doutb1 !== 7'h22) begin
      failures++; $display("FAIL coll_wf got=%h/%h exp=11/22", douta1, doutb1);
    end
    idle_ports();
    ceb = 1'b1; adb = 4'd7;
    tick();
    checks++; if (doutb0 !== 7'h11 || doutb1 !== 7'h11) begin
      failures++; $display("FAIL coll_stored got=%h/%h exp=11", doutb0, doutb1);
    end
    idle_ports();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      cea = 1'b1; wrea = 1'b1; ada = 4'(8 + i); dina = 7'(7'h40 + i);
      tick();
    end
    idle_ports();
    for (int i = 0; i < 4; i++) begin
      ceb = 1'b1; adb = 4'(8 + i);
      tick();
      checks++; if (doutb0 !== 7'(7'h40 + i)) begin
        failures++; $display("FAIL b2b_rd%0d got=%h exp=%h", i, doutb0, 7'(7'h40 + i));
      end
      if (i > 0) begin
        checks++; if (doutb2 !== 7'(7'h40 + i - 1)) begin
          failures++; $display("FAIL b2b_oreg%0d got=%h exp=%h", i, doutb2, 7'(7'h40 + i - 1));
        end
      end
    end
    ceb = 1'b0; adb = 4'd0;
    tick();
    checks++; if (doutb0 !== 7'h43 || doutb2 !== 7'h43) begin
      failures++; $display("FAIL ce_low_hold got=%h/%h exp=43", doutb0, doutb2);
    end
  endtask

  task automatic test_clear();
    int n;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (busy0 !== 1'b1 || busy3 !== 1'b1) begin
      failures++; $display("FAIL clear_start got=%b/%b exp=1/1", busy0, busy3);
    end
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      clear = (n == 6);
      if (n == 3) begin
        cea = 1'b1; wrea = 1'b1; ada = 4'd3; dina = 7'h7F;
        ceb = 1'b1; wreb = 1'b1; adb = 4'd4; dinb = 7'h7E;
      end else begin
        cea = 1'b0; wrea = 1'b0; ceb = 1'b0; wreb = 1'b0;
      end
      tick();
      if (n == 3) begin
        checks++; if (douta0 !== 7'h55 || douta1 !== 7'h43) begin
          failures++; $display("FAIL sweep_hold got=%h/%h exp=55/43", douta0, douta1);
        end
      end
    end
    idle_ports();
    checks++; if (n != 16) begin failures++; $display("FAIL clear_sweep_len got=%0d exp=16", n); end
    ceb = 1'b1; adb = 4'd3;
    tick();
    checks++; if (doutb0 !== 7'h55) begin failures++; $display("FAIL sweep_blk_a got=%h exp=55", doutb0); end
    adb = 4'd4;
    tick();
    checks++; if (doutb1 !== 7'h55) begin failures++; $display("FAIL sweep_blk_b got=%h exp=55", doutb1); end
    idle_ports();
  endtask

  task automatic test_reset_midsweep();
    int n;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    #1;
    checks++; if ({douta0, doutb0, douta1, doutb1} !== 28'd0) begin
      failures++; $display("FAIL midsweep_rst_douts got=%h exp=0", {douta0, doutb0, douta1, doutb1});
    end
    checks++; if (busy0 !== 1'b1 || busy3 !== 1'b0) begin
      failures++; $display("FAIL midsweep_rst_busy got=%b/%b exp=1/0", busy0, busy3);
    end
    #3 resetn = 1'b1;
    count_busy(n);
    checks++; if (n != 16) begin failures++; $display("FAIL restart_sweep_len got=%0d exp=16", n); end
    checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL cor0_abandon got=%b exp=0", busy3); end
    ceb = 1'b1; adb = 4'd15;
    tick();
    checks++; if (doutb0 !== 7'h55) begin failures++; $display("FAIL restart_fill got=%h exp=55", doutb0); end
    idle_ports();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_reg();
    test_rdw();
    test_collision();
    test_back_to_back();
    test_clear();
    test_reset_midsweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
